// File: rtl/vedic_pkg.sv
// Shared constants for the Vedic multiplier family: FSM encoding, default
// operand width and the sizing helpers derived from it.
package vedic_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEF_WIDTH = 32;

    function automatic int nib_count(input int width);
        return width / 4;
    endfunction

    // Tile-index counter width: enough to count all NIB*NIB nibble pairs.
    function automatic int idx_width(input int width);
        return $clog2(nib_count(width) * nib_count(width));
    endfunction

    localparam int DEF_NIB   = nib_count(DEF_WIDTH);
    localparam int DEF_IDX_W = idx_width(DEF_WIDTH);

endpackage

// File: rtl/vedic_4x4.sv
// Unsigned 4x4 Vedic (Urdhva-Tiryagbhyam) multiplier built from four 2x2
// half-adder tiles; purely combinational.
module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic t1, t2, t3, c1;
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        t3 = x[1] & y[1];
        c1 = t1 & t2;
        return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
    endfunction

    logic [3:0] m0, m1, m2, m3;
    logic [4:0] mid;

    always_comb begin
        m0  = mul2(a[1:0], b[1:0]);
        m1  = mul2(a[3:2], b[1:0]);
        m2  = mul2(a[1:0], b[3:2]);
        m3  = mul2(a[3:2], b[3:2]);
        mid = {1'b0, m1} + {1'b0, m2};
        p   = {4'b0000, m0} + {1'b0, mid, 2'b00} + {m3, 4'b0000};
    end

endmodule

// File: rtl/vedic_seq_mul.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one 4x4 Vedic tile reused for
// every nibble pair, partial products shifted and summed into acc.
module vedic_seq_mul
    import vedic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] NIB_C = IDX_W'(NIB);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIB * NIB - 1);

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [IDX_W-1:0]   idx;
    logic [2*WIDTH-1:0] acc;

    logic [IDX_W-1:0]   i_sel, j_sel;
    logic [IDX_W+1:0]   sh;
    logic [3:0]         a_nib, b_nib;
    logic [7:0]         pp;
    logic [2*WIDTH-1:0] pp_shifted;

    // idx walks a-nibble i in the outer loop and b-nibble j in the inner loop.
    always_comb begin
        i_sel      = idx / NIB_C;
        j_sel      = idx % NIB_C;
        a_nib      = a_q[{i_sel, 2'b00} +: 4];
        b_nib      = b_q[{j_sel, 2'b00} +: 4];
        sh         = {i_sel + j_sel, 2'b00};
        pp_shifted = {{(2*WIDTH-8){1'b0}}, pp} << sh;
    end

    vedic_4x4 u_tile (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the operand registers are reset too, so an
    // aborted job leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= in_a;
                    b_q   <= in_b;
                    acc   <= '0;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    acc <= acc + pp_shifted;
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_p     = acc;

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Self-checking bench for vedic_seq_mul: directed products, handshake timing,
// backpressure, mid-job reset and a randomized regression against a*b.
module tb_vedic_seq_mul;

    localparam int W   = 32;
    localparam int LAT = (W / 4) * (W / 4);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a, in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vedic_seq_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        return (2*W)'(a) * (2*W)'(b);
    endfunction

    // Present operands until accepted; returns just after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_accept: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid rises (bounded).
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic check_job(input string name, input logic [2*W-1:0] exp);
        int cyc;
        wait_out(cyc);
        checks++;
        if (cyc != LAT) begin
            failures++;
            $display("FAIL %s_latency: got=%0d required=%0d", name, cyc, LAT);
        end
        checks++;
        if (out_p !== exp) begin
            failures++;
            $display("FAIL %s_product: got=%h required=%h", name, out_p, exp);
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_release: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got=%0b required=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got=%0b required=0", out_valid); end
        checks++;
        if (out_p !== '0) begin failures++; $display("FAIL reset_out_p: got=%h required=0", out_p); end
    endtask

    task automatic test_directed;
        logic [W-1:0] va [3] = '{32'h12345678, 32'hFFFFFFFF, 32'h80000000};
        logic [W-1:0] vb [3] = '{32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00000002};
        logic [2*W-1:0] vp [3] = '{64'h0B00EA4E242D2080, 64'hFFFFFFFE00000001, 64'h0000000100000000};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(va[k], vb[k]);
            check_job("directed", vp[k]);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        int busy_bad = 0;
        out_ready = 1'b1;
        in_a = '0; in_b = 32'hDEADBEEF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 32'h0000FFFF; in_b = 32'h00010001;
        while (!out_valid && cyc < 300) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(posedge clk); #1; cyc++;
        end
        if (in_ready !== 1'b0) busy_bad++;
        checks++;
        if (busy_bad != 0) begin failures++; $display("FAIL b2b_busy: in_ready high %0d cycles required=0", busy_bad); end
        checks++;
        if (cyc != LAT) begin failures++; $display("FAIL b2b_latency: got=%0d required=%0d", cyc, LAT); end
        checks++;
        if (out_p !== '0) begin failures++; $display("FAIL b2b_zero: got=%h required=0", out_p); end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: in_ready=%0b required=0", in_ready); end
        in_valid = 1'b0;
        check_job("b2b_second", model(32'h0000FFFF, 32'h00010001));
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [2*W-1:0] exp = model(32'hCAFEF00D, 32'h13579BDF);
        int bad = 0;
        out_ready = 1'b0;
        send(32'hCAFEF00D, 32'h13579BDF);
        check_job("bp", exp);
        in_a = 32'h11111111; in_b = 32'h22222222; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_p !== exp || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_hold: %0d bad cycles required=0 (p=%h)", bad, out_p); end
        in_valid = 1'b0;
        handshake("bp");
        out_ready = 1'b0;
        send(32'h00000007, 32'h00000009);
        check_job("bp_next", 64'd63);
        handshake("bp_next");
    endtask

    task automatic test_reset_mid_run;
        int spurious = 0;
        out_ready = 1'b1;
        send(32'hA5A5A5A5, 32'h5A5A5A5A);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0) begin
            failures++;
            $display("FAIL rst_mid_async: in_ready=%0b out_valid=%0b out_p=%h required 1/0/0", in_ready, out_valid, out_p);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin failures++; $display("FAIL rst_mid_spurious: out_valid high %0d cycles required=0", spurious); end
        send(32'd3, 32'd5);
        check_job("rst_next", 64'd15);
        handshake("rst_next");
    endtask

    task automatic test_random;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] exp;
        int cyc, hold, bad_jobs, bad_lat;
        bad_jobs = 0;
        bad_lat  = 0;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 7))
                0: a = '1;
                1: a = '0;
                default: a = $urandom;
            endcase
            b   = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
            exp = model(a, b);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(a, b);
            wait_out(cyc);
            if (cyc != LAT) bad_lat++;
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_p !== exp) begin
                failures++;
                bad_jobs++;
                if (bad_jobs <= 5)
                    $display("FAIL rand_product: a=%h b=%h got=%h required=%h", a, b, out_p, exp);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (bad_lat != 0) begin failures++; $display("FAIL rand_latency: %0d jobs off required=0", bad_lat); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_run;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
